param_shadow_bank: RTL
======================

// Module: param_shadow_bank
// PURPOSE
//  Downstream consumer of the parameterization interface write/read ports. Decodes ParamWr* into
//  per-parameter shadow registers; a commit write copies all shadows to the active set atomically
//  once the application reports a safe point. Multiplexes application read-back values with a registered, 1-cycle read path.
//  Sits between the parameterization interface and the application instance, replacing per-parameter output registers and enable decoding.
// PARAMETERS
//  NumWrParams  5   number of writable parameters (write addrs 0..NumWrParams-1)
//  NumRdParams  2   number of application read-back values (read addrs 0..NumRdParams-1)
//  Width        16  parameter word width
//  WrAddrWidth  3   ParamWrAddr_i width; must hold NumWrParams (commit address)
//  RdAddrWidth  1   ParamRdAddr_i width (>= clog2(NumRdParams+NumWrParams) when readback enabled)
// PORTS
//  Clk_i             in   1                    clock, all logic on rising edge
//  Reset_i           in   1                    synchronous reset, active-high
//  ParamWrAddr_i     in   WrAddrWidth          write address
//  ParamWrData_i     in   Width                write data
//  ParamWr_i         in   1                    write strobe, one cycle per write
//  ParamRdAddr_i     in   RdAddrWidth          read address
//  ParamRdData_o     out  Width                read data, registered
//  AppRdParams_i     in   NumRdParams*Width    application values, word k at [k*Width +: Width]
//  AppIdle_i         in   1                    application at safe point (e.g. Enable low or FSM idle)
//  ActiveParams_o    out  NumWrParams*Width    active parameter set, word k at [k*Width +: Width]
//  CommitPending_o   out  1                    commit requested, not yet applied
//  CommitDone_o      out  1                    one-cycle pulse: active set updated
//  AddrErr_o         out  1                    sticky: write to address > NumWrParams
// BEHAVIOUR
//  Reset: shadows, active set, ParamRdData_o = 0; CommitPending_o, CommitDone_o, AddrErr_o = 0; FSM -> IDLE.
//  Write decode (ParamWr_i=1): addr < NumWrParams -> shadow[addr] <= data next edge; addr == NumWrParams
//   -> commit request (data ignored); addr > NumWrParams -> no register change, AddrErr_o <= 1.
//  AddrErr_o clears only on reset.
//  FSM: IDLE --commit req--> PENDING --AppIdle_i=1--> APPLY --(1 cycle)--> IDLE.
//   PENDING: CommitPending_o=1; shadow writes still accepted and included in the pending commit.
//   APPLY: active[k] <= shadow[k] (values at cycle start); CommitDone_o=1 this cycle; CommitPending_o=0.
//   Commit req while PENDING: no-op. Commit req in APPLY cycle: next state PENDING (not IDLE).
//   Shadow write in APPLY cycle: lands in shadow only; active gets pre-write value.
//   AppIdle_i already 1 at commit: IDLE->PENDING->APPLY, CommitDone_o 2 cycles after strobe.
//  Active set never changes except in APPLY or reset; shadows never reach outputs without commit.
//  Read: ParamRdData_o <= mux(ParamRdAddr_i) every cycle, latency 1, no strobe.
//   addr < NumRdParams -> AppRdParams_i word addr; otherwise 0 (see CONFIGURATION).
//  Reset asserted mid-PENDING/APPLY: pending commit discarded, all state to reset values.
// CONFIGURATION
//  PARAM_SHADOW_BANK_READBACK_EN defined: read addr NumRdParams+k (k < NumWrParams) returns active[k].
//   Active set, not shadow.
//  Undefined: those addresses read 0; no extra read mux inputs synthesized.
// STRUCTURE
//  Package param_shadow_bank_pkg: state enum {ST_IDLE, ST_PENDING, ST_APPLY};
//   function commit_addr(NumWrParams); read-back base offset constant.
//  Sub-module param_shadow_bank_fsm: commit FSM only (commit req, AppIdle_i -> pending/apply/done).
//   Register arrays and read mux stay in top.
// TESTING
//  1 Reset; write addr0=16'h1234, addr3=16'h0050 -> ActiveParams_o unchanged (0), CommitPending_o=0.
//  2 Commit (addr 5) with AppIdle_i=0 for 10 cycles -> CommitPending_o=1, active 0.
//    Raise AppIdle_i -> CommitDone_o pulses 1 cycle later; active[0]=16'h1234, active[3]=16'h0050.
//  3 During PENDING write addr1=16'h00AA, then AppIdle_i=1 -> active[1]=16'h00AA in same commit.
//  4 Commit in APPLY cycle plus write addr2=16'h7777 same cycle -> active[2] old value;
//    FSM back to PENDING; next APPLY gives 16'h7777.
//  5 Write addr 6 (NumWrParams=5) -> AddrErr_o=1 sticky, no shadow/active change; cleared only by Reset_i.
//  6 AppRdParams_i word1=16'hBEEF, ParamRdAddr_i=1 -> ParamRdData_o=16'hBEEF next cycle.
//    With READBACK_EN, addr 2 -> active[0]; without it, addr 2 -> 0.

Source files
------------

// File: rtl/param_shadow_bank_pkg.sv
// Shared types and helpers for the parameter shadow bank.
package param_shadow_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_APPLY
    } state_t;

    // Read addresses at or above NumRdParams + this offset map onto the active set.
    localparam int unsigned ReadbackBaseOffset = 0;

    // The write address one past the last parameter requests a commit.
    function automatic int unsigned commit_addr(input int unsigned numWrParams);
        return numWrParams;
    endfunction

endpackage

// File: rtl/param_shadow_bank_if.sv
// Parameterization bus between the interface block, the shadow bank and the application.
interface param_shadow_bank_if #(
    parameter int unsigned NumWrParams = 5,
    parameter int unsigned NumRdParams = 2,
    parameter int unsigned Width       = 16,
    parameter int unsigned WrAddrWidth = 3,
    parameter int unsigned RdAddrWidth = 1
);
    logic [WrAddrWidth-1:0]         ParamWrAddr_i;
    logic [Width-1:0]               ParamWrData_i;
    logic                           ParamWr_i;
    logic [RdAddrWidth-1:0]         ParamRdAddr_i;
    logic [Width-1:0]               ParamRdData_o;
    logic [NumRdParams*Width-1:0]   AppRdParams_i;
    logic                           AppIdle_i;
    logic [NumWrParams*Width-1:0]   ActiveParams_o;
    logic                           CommitPending_o;
    logic                           CommitDone_o;
    logic                           AddrErr_o;

    modport master (
        output ParamWrAddr_i, ParamWrData_i, ParamWr_i, ParamRdAddr_i,
               AppRdParams_i, AppIdle_i,
        input  ParamRdData_o, ActiveParams_o, CommitPending_o, CommitDone_o, AddrErr_o
    );

    modport slave (
        input  ParamWrAddr_i, ParamWrData_i, ParamWr_i, ParamRdAddr_i,
               AppRdParams_i, AppIdle_i,
        output ParamRdData_o, ActiveParams_o, CommitPending_o, CommitDone_o, AddrErr_o
    );

endinterface

// File: rtl/param_shadow_bank_fsm.sv
// Commit sequencer: waits for the application safe point, then asserts a one-cycle apply.
module param_shadow_bank_fsm
    import param_shadow_bank_pkg::*;
(
    input  logic Clk_i,
    input  logic Reset_i,
    input  logic commitReq,
    input  logic appIdle,
    output logic commitPending,
    output logic commitDone
);

    state_t state;

    // State transitions with registered pending/done flags.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state         <= ST_IDLE;
            commitPending <= 1'b0;
            commitDone    <= 1'b0;
        end else begin
            commitDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (commitReq) begin
                        state         <= ST_PENDING;
                        commitPending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (appIdle) begin
                        state         <= ST_APPLY;
                        commitPending <= 1'b0;
                        commitDone    <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    // A commit arriving during the apply cycle queues a fresh one.
                    if (commitReq) begin
                        state         <= ST_PENDING;
                        commitPending <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    commitPending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/param_shadow_bank.sv
// Shadow/active parameter bank with atomic commit and registered read-back mux.
// Optional: define PARAM_SHADOW_BANK_READBACK_EN to map the active set into the read space.
module param_shadow_bank
    import param_shadow_bank_pkg::*;
#(
    parameter int unsigned NumWrParams = 5,
    parameter int unsigned NumRdParams = 2,
    parameter int unsigned Width       = 16,
    parameter int unsigned WrAddrWidth = 3,
    parameter int unsigned RdAddrWidth = 1
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    param_shadow_bank_if.slave   paramIf
);

    localparam logic [WrAddrWidth-1:0] CommitAddr = WrAddrWidth'(commit_addr(NumWrParams));

    logic [Width-1:0] shadow [NumWrParams];
    logic [Width-1:0] active [NumWrParams];
    logic             commitReq;
    logic             shadowWrEn;
    logic             addrErrHit;
    logic             commitPending;
    logic             commitDone;
    logic             addrErr;
    logic [31:0]      rdAddrExt;
    logic [Width-1:0] rdNext;
    logic [Width-1:0] rdData;

    assign commitReq  = paramIf.ParamWr_i && (paramIf.ParamWrAddr_i == CommitAddr);
    assign shadowWrEn = paramIf.ParamWr_i && (paramIf.ParamWrAddr_i <  CommitAddr);
    assign addrErrHit = paramIf.ParamWr_i && (paramIf.ParamWrAddr_i >  CommitAddr);
    assign rdAddrExt  = 32'(paramIf.ParamRdAddr_i);

    param_shadow_bank_fsm commitFsm (
        .Clk_i         (Clk_i),
        .Reset_i       (Reset_i),
        .commitReq     (commitReq),
        .appIdle       (paramIf.AppIdle_i),
        .commitPending (commitPending),
        .commitDone    (commitDone)
    );

    // Shadow registers take decoded writes, including during pending and apply cycles.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            for (int unsigned k = 0; k < NumWrParams; k++) shadow[k] <= '0;
        end else if (shadowWrEn) begin
            for (int unsigned k = 0; k < NumWrParams; k++) begin
                if (paramIf.ParamWrAddr_i == WrAddrWidth'(k)) shadow[k] <= paramIf.ParamWrData_i;
            end
        end
    end

    // Active set copies the shadows as they stood at the start of the apply cycle.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            for (int unsigned k = 0; k < NumWrParams; k++) active[k] <= '0;
        end else if (commitDone) begin
            for (int unsigned k = 0; k < NumWrParams; k++) active[k] <= shadow[k];
        end
    end

    // Sticky flag for writes beyond the commit address.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) addrErr <= 1'b0;
        else if (addrErrHit) addrErr <= 1'b1;
    end

    // Read-back source selection; unmapped addresses return zero.
    always_comb begin
        rdNext = '0;
        for (int unsigned k = 0; k < NumRdParams; k++) begin
            if (rdAddrExt == k) rdNext = paramIf.AppRdParams_i[k*Width +: Width];
        end
`ifdef PARAM_SHADOW_BANK_READBACK_EN
        for (int unsigned k = 0; k < NumWrParams; k++) begin
            if (rdAddrExt == NumRdParams + ReadbackBaseOffset + k) rdNext = active[k];
        end
`endif
    end

    // Registered read path, one cycle latency.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) rdData <= '0;
        else rdData <= rdNext;
    end

    for (genvar k = 0; k < NumWrParams; k++) begin : g_activeOut
        assign paramIf.ActiveParams_o[k*Width +: Width] = active[k];
    end

    assign paramIf.ParamRdData_o   = rdData;
    assign paramIf.CommitPending_o = commitPending;
    assign paramIf.CommitDone_o    = commitDone;
    assign paramIf.AddrErr_o       = addrErr;

endmodule
